// File: rtl/board_level_data_frame_assembler.sv
// ----------------------------------------------------------------------------
// board_level_data_frame_assembler
//
// Packs the 6-bit symbol stream from the board-level physical decoder into
// an 8-bit byte stream with first/last markers. Reports frame completion,
// byte length and error status to the link layer. There is no backpressure.
// The block produces at most one byte per cycle. All outputs are registered.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   frame_start   start code received (qualified by sym_valid)
//   frame_end     end code received (qualified by sym_valid)
//   sym_data      decoded 6-bit symbol
//   sym_valid     sym_data/frame_start/frame_end valid this cycle
//   out_data      payload byte
//   out_valid     out_data valid, one-cycle strobe per byte
//   out_first     first byte of frame (qualified by out_valid)
//   out_last      final byte of frame (qualified by out_valid)
//   frame_done    one-cycle pulse at frame close
//   frame_error   frame closed abnormally (qualified by frame_done)
//   error_code    00 none, 01 misaligned end, 10 overflow, 11 nested start
//   frame_length  bytes emitted in the closed frame, held until next close
// ----------------------------------------------------------------------------
module board_level_data_frame_assembler #(
    parameter int MAX_FRAME_BYTES = 1024,
    parameter int LEN_WIDTH       = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic [5:0]           sym_data,
    input  logic                 sym_valid,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 frame_error,
    output logic [1:0]           error_code,
    output logic [LEN_WIDTH-1:0] frame_length
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_NESTED   = 2'b11;

    localparam logic [LEN_WIDTH-1:0] MAX_COUNT = LEN_WIDTH'(MAX_FRAME_BYTES);

    state_e               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [5:0]           acc_q, acc_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 first_pending_q, first_pending_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;

    logic [7:0]           out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_error_q, frame_error_d;
    logic [1:0]           error_code_q, error_code_d;
    logic [LEN_WIDTH-1:0] frame_length_q, frame_length_d;

    logic                 is_start, is_end, is_data;
    logic [7:0]           packed_byte;

    // START wins if both flags arrive together: opening a frame is the safer
    // interpretation for a corrupted control symbol.
    assign is_start = sym_valid & frame_start;
    assign is_end   = sym_valid & frame_end & ~frame_start;
    assign is_data  = sym_valid & ~frame_start & ~frame_end;

    // MSB-first concatenation: acc holds the previous symbol, and the phase
    // selects how many of its bits are still unsent.
    always_comb begin
        // NOTE: every combinational output gets a default before the case, so
        // no path leaves it unassigned and no latch is inferred.
        packed_byte = 8'h00;
        case (phase_q)
            2'd1:    packed_byte = {acc_q[5:0], sym_data[5:4]};
            2'd2:    packed_byte = {acc_q[3:0], sym_data[5:2]};
            2'd3:    packed_byte = {acc_q[1:0], sym_data[5:0]};
            default: packed_byte = 8'h00;
        endcase
    end

    always_comb begin
        logic       close_frame;
        logic [1:0] close_code;
        logic       open_frame;

        state_d         = state_q;
        phase_d         = phase_q;
        acc_d           = acc_q;
        hold_d          = hold_q;
        hold_valid_d    = hold_valid_q;
        first_pending_d = first_pending_q;
        count_d         = count_q;
        out_data_d      = out_data_q;
        out_valid_d     = 1'b0;
        out_first_d     = 1'b0;
        out_last_d      = 1'b0;
        frame_done_d    = 1'b0;
        frame_error_d   = 1'b0;
        error_code_d    = ERR_NONE;
        frame_length_d  = frame_length_q;
        close_frame     = 1'b0;
        close_code      = ERR_NONE;
        open_frame      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_start) open_frame = 1'b1;
            end
            ST_RECV: begin
                if (is_start) begin
                    close_frame = 1'b1;
                    close_code  = ERR_NESTED;
                    open_frame  = 1'b1;
                end else if (is_end) begin
                    close_frame = 1'b1;
                    close_code  = (phase_q == 2'd0) ? ERR_NONE : ERR_MISALIGN;
                    state_d     = ST_IDLE;
                end else if (is_data) begin
                    acc_d   = sym_data;
                    phase_d = phase_q + 2'd1;
                    if (phase_q != 2'd0) begin
                        if (count_q == MAX_COUNT) begin
                            // The byte that would exceed the limit is dropped.
                            // The frame closes on the byte already held.
                            close_frame = 1'b1;
                            close_code  = ERR_OVERFLOW;
                            state_d     = ST_DISCARD;
                        end else begin
                            // The new byte replaces the held one, and the
                            // held byte leaves. It is not last, because
                            // another byte follows it.
                            hold_d       = packed_byte;
                            hold_valid_d = 1'b1;
                            count_d      = count_q + LEN_WIDTH'(1);
                            if (hold_valid_q) begin
                                out_valid_d     = 1'b1;
                                out_data_d      = hold_q;
                                out_first_d     = first_pending_q;
                                first_pending_d = 1'b0;
                            end
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (is_start)    open_frame = 1'b1;
                else if (is_end) state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (close_frame) begin
            if (hold_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_first_d = first_pending_q;
                out_last_d  = 1'b1;
            end
            hold_valid_d   = 1'b0;
            frame_done_d   = 1'b1;
            frame_error_d  = (close_code != ERR_NONE);
            error_code_d   = close_code;
            frame_length_d = count_q;
        end

        if (open_frame) begin
            state_d         = ST_RECV;
            phase_d         = 2'd0;
            count_d         = '0;
            hold_valid_d    = 1'b0;
            first_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            state_q         <= ST_IDLE;
            phase_q         <= 2'd0;
            acc_q           <= '0;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            first_pending_q <= 1'b0;
            count_q         <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_first_q     <= 1'b0;
            out_last_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            error_code_q    <= ERR_NONE;
            frame_length_q  <= '0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            acc_q           <= acc_d;
            hold_q          <= hold_d;
            hold_valid_q    <= hold_valid_d;
            first_pending_q <= first_pending_d;
            count_q         <= count_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_first_q     <= out_first_d;
            out_last_q      <= out_last_d;
            frame_done_q    <= frame_done_d;
            frame_error_q   <= frame_error_d;
            error_code_q    <= error_code_d;
            frame_length_q  <= frame_length_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;
    assign error_code   = error_code_q;
    assign frame_length = frame_length_q;

endmodule

// File: tb/tb_board_level_data_frame_assembler.sv
// ----------------------------------------------------------------------------
// Bench for board_level_data_frame_assembler. Two instances share one input
// stream: "big" uses the default frame limit (1024), and "small" uses a
// frame limit of 3 so that the overflow path is reachable. The reference
// model treats each frame as a growing bit string. It emits bytes from that
// string with a one-byte delay so that the final byte can carry the last
// marker.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_board_level_data_frame_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0, frame_end = 1'b0, sym_valid = 1'b0;
    logic [5:0]  sym_data = '0;

    logic [7:0]  b_data, s_data;
    logic        b_valid, b_first, b_last, b_done, b_err;
    logic        s_valid, s_first, s_last, s_done, s_err;
    logic [1:0]  b_code, s_code;
    logic [10:0] b_len, s_len;

    always #5 clk = ~clk;

    board_level_data_frame_assembler #(.MAX_FRAME_BYTES(1024), .LEN_WIDTH(11)) dut_big (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .sym_data(sym_data), .sym_valid(sym_valid),
        .out_data(b_data), .out_valid(b_valid), .out_first(b_first), .out_last(b_last),
        .frame_done(b_done), .frame_error(b_err), .error_code(b_code), .frame_length(b_len));

    board_level_data_frame_assembler #(.MAX_FRAME_BYTES(3), .LEN_WIDTH(11)) dut_small (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .sym_data(sym_data), .sym_valid(sym_valid),
        .out_data(s_data), .out_valid(s_valid), .out_first(s_first), .out_last(s_last),
        .frame_done(s_done), .frame_error(s_err), .error_code(s_code), .frame_length(s_len));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (index 0 = big, 1 = small) -----------
    int m_max[2] = '{1024, 3};
    int m_mode[2];      // 0 idle, 1 receiving, 2 discarding
    int m_buf[2];       // unsent frame bits, right-aligned
    int m_nbits[2];
    int m_hold[2];
    bit m_have_hold[2];
    int m_nbytes[2];    // bytes accepted into the frame so far
    int m_emitted[2];   // bytes already sent out for the frame

    bit e_valid[2], e_first[2], e_last[2], e_done[2], e_err[2];
    int e_data[2], e_code[2], e_len[2];

    int dbyte[2][$], mbyte[2][$], ddone[2][$], mdone[2][$];

    task automatic m_emit(input int k, input int b, input bit last);
        e_valid[k] = 1; e_data[k] = b; e_first[k] = (m_emitted[k] == 0); e_last[k] = last;
        m_emitted[k]++;
    endtask

    task automatic m_close(input int k, input int code);
        if (m_have_hold[k]) m_emit(k, m_hold[k], 1);
        m_have_hold[k] = 0;
        e_done[k] = 1; e_err[k] = (code != 0); e_code[k] = code; e_len[k] = m_nbytes[k];
    endtask

    task automatic m_open(input int k);
        m_mode[k] = 1; m_buf[k] = 0; m_nbits[k] = 0; m_have_hold[k] = 0;
        m_nbytes[k] = 0; m_emitted[k] = 0;
    endtask

    task automatic m_step(input int k, input bit r, input bit v, input bit fs, input bit fe, input int s);
        int b;
        e_valid[k] = 0; e_first[k] = 0; e_last[k] = 0; e_done[k] = 0; e_err[k] = 0; e_code[k] = 0;
        if (r) begin
            m_mode[k] = 0; m_have_hold[k] = 0; e_data[k] = 0; e_len[k] = 0;
            return;
        end
        if (!v) return;
        case (m_mode[k])
            0: if (fs) m_open(k);
            1: begin
                if (fs) begin
                    m_close(k, 3);
                    m_open(k);
                end else if (fe) begin
                    m_close(k, (m_nbits[k] != 0) ? 1 : 0);
                    m_mode[k] = 0;
                end else begin
                    m_buf[k] = (m_buf[k] << 6) | s;
                    m_nbits[k] += 6;
                    if (m_nbits[k] >= 8) begin
                        b = (m_buf[k] >> (m_nbits[k] - 8)) & 255;
                        m_nbits[k] -= 8;
                        m_buf[k] &= (1 << m_nbits[k]) - 1;
                        if (m_nbytes[k] == m_max[k]) begin
                            m_close(k, 2);
                            m_mode[k] = 2;
                        end else begin
                            if (m_have_hold[k]) m_emit(k, m_hold[k], 0);
                            m_hold[k] = b; m_have_hold[k] = 1; m_nbytes[k]++;
                        end
                    end
                end
            end
            default: begin
                if (fs) m_open(k);
                else if (fe) m_mode[k] = 0;
            end
        endcase
    endtask

    task automatic compare_one(input int k, input logic v, input logic [7:0] d, input logic f,
                               input logic l, input logic dn, input logic er,
                               input logic [1:0] c, input logic [10:0] len);
        string p;
        int tmp;
        p = (k == 0) ? "big" : "small";
        check($sformatf("%s_out_valid", p), v, e_valid[k]);
        if (e_valid[k]) begin
            check($sformatf("%s_out_data", p), d, e_data[k]);
            check($sformatf("%s_out_first", p), f, e_first[k]);
            check($sformatf("%s_out_last", p), l, e_last[k]);
        end
        check($sformatf("%s_frame_done", p), dn, e_done[k]);
        if (e_done[k]) begin
            check($sformatf("%s_frame_error", p), er, e_err[k]);
            check($sformatf("%s_error_code", p), c, e_code[k]);
        end
        check($sformatf("%s_frame_length", p), len, e_len[k]);
        if (v === 1'b1) begin
            tmp = {f, l, d};
            dbyte[k].push_back(tmp);
        end
        if (dn === 1'b1) ddone[k].push_back((int'(er) << 16) | (int'(c) << 12) | int'(len));
        if (e_valid[k]) mbyte[k].push_back((int'(e_first[k]) << 9) | (int'(e_last[k]) << 8) | e_data[k]);
        if (e_done[k]) mdone[k].push_back((int'(e_err[k]) << 16) | (e_code[k] << 12) | e_len[k]);
    endtask

    // Single compare process: advance the model on each edge, check 1ns later.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) m_step(k, rst, sym_valid, frame_start, frame_end, int'(sym_data));
        #1;
        compare_one(0, b_valid, b_data, b_first, b_last, b_done, b_err, b_code, b_len);
        compare_one(1, s_valid, s_data, s_first, s_last, s_done, s_err, s_code, s_len);
    end

    // ---------------- hand-computed expectations ---------------------------
    // Byte entries are {first, last, data}. Done entries are err<<16 | code<<12 | length.
    int exp_b[$], exp_d[$];

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            dbyte[k].delete(); mbyte[k].delete(); ddone[k].delete(); mdone[k].delete();
        end
    endtask

    task automatic check_logs(input string name, input int k);
        check({name, "_nbytes"}, dbyte[k].size(), exp_b.size());
        check({name, "_model_nbytes"}, mbyte[k].size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < dbyte[k].size()) check($sformatf("%s_byte%0d", name, i), dbyte[k][i], exp_b[i]);
            if (i < mbyte[k].size()) check($sformatf("%s_model_byte%0d", name, i), mbyte[k][i], exp_b[i]);
        end
        check({name, "_ndone"}, ddone[k].size(), exp_d.size());
        check({name, "_model_ndone"}, mdone[k].size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < ddone[k].size()) check($sformatf("%s_done%0d", name, i), ddone[k][i], exp_d[i]);
            if (i < mdone[k].size()) check($sformatf("%s_model_done%0d", name, i), mdone[k][i], exp_d[i]);
        end
    endtask

    // ---------------- stimulus ---------------------------------------------
    task automatic sym(input bit fs, input bit fe, input logic [5:0] d);
        @(negedge clk);
        sym_valid = 1'b1; frame_start = fs; frame_end = fe; sym_data = d;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            sym_valid = 1'b0;
            frame_start = 1'($urandom_range(0, 1));
            frame_end   = 1'($urandom_range(0, 1));
            sym_data    = 6'($urandom);
        end
    endtask

    task automatic dat(input logic [5:0] d, input bit gaps);
        if (gaps) gap($urandom_range(0, 3));
        sym(0, 0, d);
    endtask

    task automatic frame4(input bit gaps);
        dat(6'h3F, gaps); dat(6'h00, gaps); dat(6'h2A, gaps); dat(6'h15, gaps);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_big"}, {b_valid, b_first, b_last, b_done, b_err, b_code, b_data, b_len}, 0);
        check({name, "_small"}, {s_valid, s_first, s_last, s_done, s_err, s_code, s_data, s_len}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        rst = 1'b0;

        // Clean frame: 0xFC(first) 0x0A 0x95(last), length 3.
        clear_logs();
        sym(1, 0, 0); frame4(0); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h00A, 32'h195}; exp_d = {32'h00003};
        check_logs("clean", 0);

        // Misaligned end: 0xFC(first) 0x0A(last), code 01, length 2.
        clear_logs();
        sym(1, 0, 0); dat(6'h3F, 0); dat(6'h00, 0); dat(6'h2A, 0); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h10A}; exp_d = {32'h11002};
        check_logs("misalign", 0);

        // Overflow on the 3-byte instance. Later DATA and END are silent.
        clear_logs();
        sym(1, 0, 0); frame4(0); frame4(0); gap(2); dat(6'h11, 0); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h00A, 32'h195}; exp_d = {32'h12003};
        check_logs("overflow", 1);

        // Nested start: A closes with code 11. B is a clean frame.
        clear_logs();
        sym(1, 0, 0); frame4(0); sym(1, 0, 0); frame4(0); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h00A, 32'h195, 32'h2FC, 32'h00A, 32'h195};
        exp_d = {32'h13003, 32'h00003};
        check_logs("nested", 0);

        // Empty frame, followed by DATA while idle.
        clear_logs();
        sym(1, 0, 0); sym(0, 1, 0); dat(6'h3F, 0); dat(6'h00, 0); dat(6'h2A, 0); gap(3);
        exp_b = {}; exp_d = {32'h00000};
        check_logs("empty_idle", 0);

        // Gaps inside a frame give the same bytes as the gap-free frame.
        clear_logs();
        sym(1, 0, 0); frame4(1); gap(2); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h00A, 32'h195}; exp_d = {32'h00003};
        check_logs("gaps", 0);

        // Reset mid-frame after 2 bytes: outputs clear, no frame_done.
        clear_logs();
        sym(1, 0, 0); dat(6'h3F, 0); dat(6'h00, 0); dat(6'h2A, 0);
        @(negedge clk); sym_valid = 1'b0; rst = 1'b1;
        @(negedge clk); check_zero_outputs("midframe_reset");
        rst = 1'b0;
        check("midframe_reset_no_done", ddone[0].size(), 0);
        clear_logs();
        sym(1, 0, 0); frame4(0); sym(0, 1, 0); gap(3);
        exp_b = {32'h2FC, 32'h00A, 32'h195}; exp_d = {32'h00003};
        check_logs("after_reset", 0);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 999);
            rst = (r < 2);
            sym_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            frame_start = (r < 7);
            frame_end = (r >= 7 && r < 17);
            sym_data = 6'($urandom);
        end
        @(negedge clk); rst = 1'b0; sym_valid = 1'b0;
        gap(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_level_data_frame_assembler.md
Name: board_level_data_frame_assembler

Overview:
- Sits directly downstream of the board-level physical decoder. Consumes its frame_start, frame_end and 6-bit symbol stream, and packs the symbols into an 8-bit byte stream with first/last markers.
- Reports per-frame completion, byte length and error status to the link layer.
- Has no backpressure, because the upstream stage has none. At most one byte is produced per cycle.

Parameters:
MAX_FRAME_BYTES, 1024, maximum payload bytes per frame; any further byte is an overflow.
LEN_WIDTH, 11, width of frame_length; must hold MAX_FRAME_BYTES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
frame_start  input  1  start code received (qualified by sym_valid)
frame_end  input  1  end code received (qualified by sym_valid)
sym_data  input  6  decoded symbol
sym_valid  input  1  sym_data/frame_start/frame_end valid this cycle
out_data  output  8  payload byte
out_valid  output  1  out_data valid (one-cycle strobe per byte)
out_first  output  1  first byte of frame, qualified by out_valid
out_last  output  1  final byte of frame, qualified by out_valid
frame_done  output  1  one-cycle pulse at frame close
frame_error  output  1  frame closed abnormally, qualified by frame_done
error_code  output  2  00 none, 01 misaligned end, 10 overflow, 11 nested start; qualified by frame_done
frame_length  output  LEN_WIDTH  bytes emitted in the closed frame; held until the next frame_done

Behaviour:
- Reset: all outputs 0, state IDLE, hold register empty, phase 0, byte count 0. Reset mid-frame drops the partial frame silently, with no frame_done.
- Symbol classes, evaluated only when sym_valid=1:
  - START: frame_start=1.
  - END: frame_end=1.
  - DATA: neither flag set.
  - When sym_valid=0 all inputs are ignored; gaps inside a frame are legal.
- Packing: MSB-first concatenation of 6-bit symbols with a 2-bit phase counter.
  - phase0: symbol fills acc[5:0]; no byte.
  - phase1: byte = {acc[5:0], s[5:4]}.
  - phase2: byte = {acc[3:0], s[5:2]}.
  - phase3: byte = {acc[1:0], s[5:0]}.
  - Phase wraps 3→0.
- One-byte hold register: each completed byte is written into hold. The previously held byte, if any, is emitted to out_* on the same edge. This lets the final byte carry out_last.
  - Latency: a byte completed by the symbol on cycle N appears on out_* no earlier than N+1.
- out_first=1 on the first byte emitted after frame open.
- FSM IDLE:
  - START: go to RECV; clear phase, count and hold.
  - DATA/END: ignored.
- FSM RECV:
  - DATA: pack as above.
  - Overflow: if a byte completes while count==MAX_FRAME_BYTES:
    - Emit the held byte with out_last=1.
    - Pulse frame_done with frame_error=1, error_code=10, frame_length=count.
    - Go to DISCARD.
  - END with phase==0:
    - Emit the held byte with out_last=1 and pulse frame_done with error=0, length=count, on the same edge.
    - Empty frame (no bytes): frame_done only, out_valid=0, length=0.
    - Go to IDLE.
  - END with phase!=0:
    - Residual bits are dropped.
    - Emit the held byte as last, if present, and pulse frame_done with error=1, code=01.
    - Go to IDLE.
  - START (nested):
    - Close the current frame exactly as in the END cases, but with code=11.
    - Reopen immediately: stay in RECV with phase, count and hold cleared.
- FSM DISCARD:
  - DATA: ignored.
  - END: go to IDLE with no pulse.
  - START: go to RECV (fresh frame).
- Count increments when a byte enters hold, saturating at MAX_FRAME_BYTES. frame_length equals the number of bytes emitted for that frame.
- out_valid, frame_done and the markers are single-cycle strobes. They are registered outputs only.

Test Plan:
- START, DATA 0x3F, 0x00, 0x2A, 0x15, END → bytes 0xFC(first), 0x0A, 0x95(last); frame_done with error=0, length=3.
- START, DATA 0x3F, 0x00, 0x2A, END → bytes 0xFC(first), 0x0A(last); frame_done with error=1, code=01, length=2; residual bits dropped.
- MAX_FRAME_BYTES=3: START, 8 DATA symbols → 3 bytes, third marked last, frame_done with code=10, length=3. Later DATA ignored; the following END produces no pulse.
- START, 4 DATA, START, 4 DATA, END → frame A closes with code=11, length=3. Frame B then outputs 3 bytes with out_first on its first byte and error=0.
- START, END → frame_done with length=0, no out_valid. Symbols with random sym_valid=0 gaps inside a frame → identical bytes to the gap-free case. DATA while IDLE → no output.
- Assert rst mid-frame after 2 bytes → all outputs 0, no frame_done. The next START, 4 DATA, END frame decodes cleanly.
